// File: rtl/muldiv_ctrl.sv
// Iterative unsigned multiply/divide sequencer owning the HI/LO registers.
// One shift-add (MULT) or restoring (DIV) step per cycle for WIDTH cycles.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic               op_r;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted_rem;
    logic               accept;
    logic               div_zero;
    logic               last;

    assign accept   = start && (state != RUN);
    assign div_zero = op && (b == '0);
    assign last     = (state == RUN) && (count == CW'(WIDTH - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = div_zero ? DONE : RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? (div_zero ? DONE : RUN) : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // acc holds {carry, product_hi, multiplier/product_lo} for MULT and
    // {rem (WIDTH+1 bits), quo} for DIV, so one register serves both.
    always_comb begin
        sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted_rem = acc[2*WIDTH-1:WIDTH-1];
        acc_step    = acc >> 1;
        if (!op_r) begin
            if (acc[0]) acc_step = {sum, acc[WIDTH-1:0]} >> 1;
        end else if (shifted_rem >= {1'b0, operand}) begin
            acc_step = {shifted_rem - {1'b0, operand}, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {shifted_rem, acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            op_r    <= 1'b0;
            operand <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r    <= op;
                operand <= op ? b : a;
                acc     <= {{(WIDTH+1){1'b0}}, (op ? a : b)};
                count   <= '0;
            end else if (state == RUN) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end
            // Moves are blocked while running; a result landing later wins.
            if (state != RUN) begin
                if (wr_hi) hi <= wd;
                if (wr_lo) lo <= wd;
            end
            if (last) begin
                hi <= acc_step[2*WIDTH-1:WIDTH];
                lo <= acc_step[WIDTH-1:0];
            end else if (accept && div_zero) begin
                hi <= '0;
                lo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized MULT/DIV mix against 64-bit arithmetic.
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wd    = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs afterwards, count busy cycles
    // and compare the result, the done pulse and HI/LO hold during RUN.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int cyc;
        int exp_cyc;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        logic held;
        @(negedge clock);
        hold_hi = hi;
        hold_lo = lo;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom; op = ~o;
        cyc  = 0;
        held = 1'b1;
        while (busy && cyc < 100) begin
            if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
            @(negedge clock);
            cyc++;
        end
        exp_cyc = (o && y == 32'd0) ? 0 : 32;
        chk({nm, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, " hold"}, {63'd0, held}, 64'd1);
        chk({nm, " done"}, {63'd0, done}, 64'd1);
        chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
        chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
        @(negedge clock);
        chk({nm, " done_clear"}, {63'd0, done}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        int cyc;
        logic [63:0] p;
        logic [31:0] x;
        logic [31:0] y;
        logic        o;
        bit          saw_done;

        vecs.push_back('{1'b0, 32'd3, 32'd5, 32'h0, 32'hF, "mult3x5"});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, "mult_max"});
        vecs.push_back('{1'b0, 32'd0, 32'h12345678, 32'h0, 32'h0, "mult_zero"});
        vecs.push_back('{1'b0, 32'h80000000, 32'd4, 32'h2, 32'h0, "mult_carry"});
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, "div100_7"});
        vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, "div_big"});
        vecs.push_back('{1'b1, 32'd5, 32'd0, 32'h0, 32'h0, "div_by0"});
        vecs.push_back('{1'b1, 32'd3, 32'd10, 32'd3, 32'd0, "div_a_lt_b"});
        vecs.push_back('{1'b1, 32'd9, 32'd9, 32'd0, 32'd1, "div_a_eq_b"});
        vecs.push_back('{1'b1, 32'hCAFEF00D, 32'd1, 32'd0, 32'hCAFEF00D, "div_by1"});
        vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'h10000, 32'hFFFF, 32'hFFFF, "div_pow2"});

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        // MTHI/MTLO in IDLE take effect on the next edge
        @(negedge clock);
        wr_hi = 1'b1; wd = 32'hDEADBEEF;
        @(negedge clock);
        wr_hi = 1'b0;
        chk("mthi idle", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
        wr_lo = 1'b1; wd = 32'h12345678;
        @(negedge clock);
        wr_lo = 1'b0;
        chk("mtlo idle", {32'd0, lo}, {32'd0, 32'h12345678});
        chk("mtlo keeps hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});

        // Directed vector table
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

        // Stray starts during RUN, then back-to-back DIV issued during DONE
        @(negedge clock);
        op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            start = (cyc == 5 || cyc == 20);
            op = 1'b1; a = 32'd1; b = 32'd1;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk("b2b first latency", 64'(cyc), 64'd33);
        chk("b2b first hi", {32'd0, hi}, 64'd0);
        chk("b2b first lo", {32'd0, lo}, 64'd15);
        op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("b2b second busy", {63'd0, busy}, 64'd1);
        chk("b2b second done", {63'd0, done}, 64'd0);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("b2b second latency", 64'(cyc), 64'd33);
        chk("b2b second hi", {32'd0, hi}, 64'd2);
        chk("b2b second lo", {32'd0, lo}, 64'd14);

        // Moves during RUN are ignored; the product lands at the end
        @(negedge clock);
        op = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            wr_hi = (cyc == 10); wr_lo = (cyc == 10);
            wd = 32'hDEADBEEF;
            @(negedge clock);
            if (cyc == 12) chk("mt during run hi", {32'd0, hi}, 64'd2);
            cyc++;
        end
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt during run result hi", {32'd0, hi}, 64'd0);
        chk("mt during run result lo", {32'd0, lo}, 64'd15);

        // Start and MTHI together: write visible now, result overwrites later
        @(negedge clock);
        op = 1'b0; a = 32'd2; b = 32'd2; start = 1'b1; wr_hi = 1'b1; wd = 32'hA5A5A5A5;
        @(negedge clock);
        start = 1'b0; wr_hi = 1'b0;
        chk("start+mthi write", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("start+mthi result hi", {32'd0, hi}, 64'd0);
        chk("start+mthi result lo", {32'd0, lo}, 64'd4);

        // Asynchronous reset mid-MULT after preloading HI/LO
        @(negedge clock);
        wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h11111111;
        @(negedge clock);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("preload hi", {32'd0, hi}, {32'd0, 32'h11111111});
        op = 1'b0; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", {63'd0, busy}, 64'd0);
        chk("async reset hi", {32'd0, hi}, 64'd0);
        chk("async reset lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        chk("no done after reset", {63'd0, saw_done}, 64'd0);
        run_op(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, "mult6x7 after reset");

        // Randomized mix with forced edge cases
        for (int i = 0; i < 300; i++) begin
            o = $urandom_range(0, 1);
            x = $urandom;
            y = $urandom;
            case (i % 6)
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = x + 32'd1 + 32'($urandom_range(0, 100));
                3: y = x;
                4: y = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if (o) begin
                if (y == 32'd0) p = 64'd0;
                else p = {32'(x % y), 32'(x / y)};
            end else begin
                p = {32'd0, x} * {32'd0, y};
            end
            run_op(o, x, y, p[63:32], p[31:0], $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
